// File: rtl/regfile_nr.sv
// Multi-port register file: one synchronous write port, two combinational read ports,
// hardwired-zero register. Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_nr #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 31,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_reg,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_reg1,
    input  logic [AW-1:0]    read_reg2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2
);

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ZERO_L  = AW'(ZERO_REG);

    logic [WIDTH-1:0] regs_r [DEPTH];
    logic             write_hit_s;

    // An index is live only when it addresses real storage other than the zero register.
    function automatic logic idx_live(input logic [AW-1:0] idx);
        return ({1'b0, idx} < DEPTH_L) && (idx != ZERO_L);
    endfunction

    // Dead indices read as zero so the stored zero-register slot is never observable.
    function automatic logic [WIDTH-1:0] rd_mux(input logic [AW-1:0] idx);
        logic [WIDTH-1:0] val_s;
        val_s = {WIDTH{1'b0}};
        if (idx_live(idx)) begin
            val_s = regs_r[idx];
        end else begin
            val_s = {WIDTH{1'b0}};
        end
        return val_s;
    endfunction

    // Qualify the write strobe against the zero register and out-of-range indices.
    always_comb begin
        write_hit_s = 1'b0;
        if (write_enable && idx_live(write_reg)) begin
            write_hit_s = 1'b1;
        end else begin
            write_hit_s = 1'b0;
        end
    end

    // Storage update; reset clears everything and overrides any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (write_hit_s && (write_reg == AW'(i))) begin
                    regs_r[i] <= write_data;
                end
            end
        end
    end

    // Combinational read ports with optional same-cycle write forwarding.
    always_comb begin
        read_data1 = {WIDTH{1'b0}};
        read_data2 = {WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
        if (write_hit_s && !reset && (read_reg1 == write_reg)) begin
            read_data1 = write_data;
        end else begin
            read_data1 = rd_mux(read_reg1);
        end
        if (write_hit_s && !reset && (read_reg2 == write_reg)) begin
            read_data2 = write_data;
        end else begin
            read_data2 = rd_mux(read_reg2);
        end
`else
        read_data1 = rd_mux(read_reg1);
        read_data2 = rd_mux(read_reg2);
`endif
    end

endmodule
